// File: rtl/view_scan_sequencer_pkg.sv
// Shared definitions for the view scan sequencer: default bus widths, viewer mode codes,
// FSM state encoding and the tap-index width helper.
package view_scan_sequencer_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 6;
    localparam int unsigned OFF_W_DEFAULT  = 4;
    localparam int unsigned MODE_W_DEFAULT = 2;

    localparam int unsigned MODE_BLOCK = 0;
    localparam int unsigned MODE_WORD  = 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StScan  = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

    // Width of an index covering all (2r+1)^2 taps of a sweep.
    function automatic int unsigned idx_width(input int unsigned radius);
        return $clog2((2 * radius + 1) * (2 * radius + 1));
    endfunction

endpackage

// File: rtl/view_scan_sequencer_if.sv
// Bundle between the scan sequencer and its neighbours.
//   start_*            : scan request handshake (valid/ready) with centre address and viewer mode
//   hold               : freezes tap issue while a scan is running
//   rw, mem_addr       : CTRL_MEMORY port A control
//   view_mode/off_x/y  : MEMORY_VIEWER control
//   tap_valid/idx/last : tap stream aligned with the viewer output
//   busy, done         : scan status
// modport slave is the sequencer side; modport master is the requester/consumer side.
interface view_scan_sequencer_if
    import view_scan_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned OFF_W  = OFF_W_DEFAULT,
    parameter int unsigned MODE_W = MODE_W_DEFAULT,
    parameter int unsigned IDX_W  = 4
);

    logic              start_valid;
    logic              start_ready;
    logic [ADDR_W-1:0] start_addr;
    logic [MODE_W-1:0] start_mode;
    logic              hold;
    logic              rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [MODE_W-1:0] view_mode;
    logic [OFF_W-1:0]  view_off_x;
    logic [OFF_W-1:0]  view_off_y;
    logic              tap_valid;
    logic [IDX_W-1:0]  tap_idx;
    logic              tap_last;
    logic              busy;
    logic              done;

    modport slave (
        input  start_valid, start_addr, start_mode, hold,
        output start_ready, rw, mem_addr, view_mode, view_off_x, view_off_y,
        output tap_valid, tap_idx, tap_last, busy, done
    );

    modport master (
        output start_valid, start_addr, start_mode, hold,
        input  start_ready, rw, mem_addr, view_mode, view_off_x, view_off_y,
        input  tap_valid, tap_idx, tap_last, busy, done
    );

endinterface

// File: rtl/view_scan_sequencer_tap_delay_line.sv
// DEPTH-stage shift register carrying {valid, idx, last} for each issued tap so the tap
// stream lines up with the viewer pipeline. Synchronous clear on rst.
//   clk, rst                      : clock, synchronous active-high clear
//   push_valid/push_idx/push_last : entry entering the line this cycle
//   tap_valid/tap_idx/tap_last    : entry leaving the line (registered)
module view_scan_sequencer_tap_delay_line #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    input  logic [IDX_W-1:0] push_idx,
    input  logic             push_last,
    output logic             tap_valid,
    output logic [IDX_W-1:0] tap_idx,
    output logic             tap_last
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] last_q;
    logic [IDX_W-1:0] idx_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            last_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= push_valid;
            last_q[0]  <= push_last;
            idx_q[0]   <= push_idx;
            for (int i = 1; i < int'(DEPTH); i++) begin
                valid_q[i] <= valid_q[i-1];
                last_q[i]  <= last_q[i-1];
                idx_q[i]   <= idx_q[i-1];
            end
        end
    end

    assign tap_valid = valid_q[DEPTH-1];
    assign tap_last  = last_q[DEPTH-1];
    assign tap_idx   = idx_q[DEPTH-1];

endmodule

// File: rtl/view_scan_sequencer.sv
// Drives CTRL_MEMORY port A and MEMORY_VIEWER through a (2*RADIUS+1)^2 sweep of signed view
// offsets around one centre address, one tap per cycle (y outer, x inner), and emits a tap
// stream delayed by PIPE_LAT so it lines up with the viewer output.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of view_scan_sequencer_if (start handshake, hold, memory/viewer
//              control, tap stream, busy/done)
module view_scan_sequencer
    import view_scan_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEFAULT,
    parameter int unsigned OFF_W    = OFF_W_DEFAULT,
    parameter int unsigned MODE_W   = MODE_W_DEFAULT,
    parameter int unsigned RADIUS   = 1,
    parameter int unsigned PIPE_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    view_scan_sequencer_if.slave bus
);

    localparam int unsigned IDX_W = idx_width(RADIUS);
    localparam int unsigned DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [OFF_W-1:0] OFF_ONE    = OFF_W'(1);
    localparam logic [OFF_W-1:0] POS_R      = OFF_W'(RADIUS);
    localparam logic [OFF_W-1:0] NEG_R      = OFF_W'(0) - POS_R;
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [DRN_W-1:0] DRN_ONE    = DRN_W'(1);
    localparam logic [DRN_W-1:0] DRAIN_INIT = DRN_W'(PIPE_LAT - 1);

    if (RADIUS < 1 || RADIUS > (2 ** (OFF_W - 1)) - 1) begin : g_bad_radius
        $error("view_scan_sequencer: RADIUS %0d does not fit a signed %0d-bit offset",
               RADIUS, OFF_W);
    end
    if (PIPE_LAT < 1) begin : g_bad_lat
        $error("view_scan_sequencer: PIPE_LAT must be at least 1");
    end

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [MODE_W-1:0] mode_q;
    logic [OFF_W-1:0]  off_x_q;
    logic [OFF_W-1:0]  off_y_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DRN_W-1:0]  drain_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;

    logic              scan_last;
    logic              push_valid;
    logic [IDX_W-1:0]  push_idx;
    logic              push_last;

    // The tap currently on the offset outputs is issued only in a SCAN cycle without hold;
    // every other cycle pushes an all-zero bubble.
    always_comb begin
        scan_last  = (off_x_q == POS_R) && (off_y_q == POS_R);
        push_valid = (state_q == StScan) && !bus.hold;
        push_idx   = push_valid ? idx_q : '0;
        push_last  = push_valid && scan_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            mode_q  <= '0;
            off_x_q <= '0;
            off_y_q <= '0;
            idx_q   <= '0;
            drain_q <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start_valid && ready_q) begin
                        addr_q  <= bus.start_addr;
                        mode_q  <= bus.start_mode;
                        off_x_q <= NEG_R;
                        off_y_q <= NEG_R;
                        idx_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StScan;
                    end
                end
                StScan: begin
                    if (!bus.hold) begin
                        if (scan_last) begin
                            off_x_q <= '0;
                            off_y_q <= '0;
                            drain_q <= DRAIN_INIT;
                            state_q <= StDrain;
                        end else begin
                            idx_q <= idx_q + IDX_ONE;
                            if (off_x_q == POS_R) begin
                                off_x_q <= NEG_R;
                                off_y_q <= off_y_q + OFF_ONE;
                            end else begin
                                off_x_q <= off_x_q + OFF_ONE;
                            end
                        end
                    end
                end
                StDrain: begin
                    // Wait until the final tap has left the delay line.
                    if (drain_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        drain_q <= drain_q - DRN_ONE;
                    end
                end
                StDone: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    logic             dl_valid;
    logic [IDX_W-1:0] dl_idx;
    logic             dl_last;

    view_scan_sequencer_tap_delay_line #(
        .DEPTH (PIPE_LAT),
        .IDX_W (IDX_W)
    ) u_tap_delay_line (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_idx   (push_idx),
        .push_last  (push_last),
        .tap_valid  (dl_valid),
        .tap_idx    (dl_idx),
        .tap_last   (dl_last)
    );

    assign bus.start_ready = ready_q;
    assign bus.rw          = 1'b1;
    assign bus.mem_addr    = addr_q;
    assign bus.view_mode   = mode_q;
    assign bus.view_off_x  = off_x_q;
    assign bus.view_off_y  = off_y_q;
    assign bus.tap_valid   = dl_valid;
    assign bus.tap_idx     = dl_idx;
    assign bus.tap_last    = dl_last;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_view_scan_sequencer.sv
// Two sequencers (RADIUS 1 and 2, PIPE_LAT 2) share one random stimulus stream. The driver
// keeps a per-DUT sweep model and queues the expected tap stream and done pulses by cycle;
// the monitor checks direct outputs against the model and pops the queues on the cycle
// each entry is due.
module tb_view_scan_sequencer;
    import view_scan_sequencer_pkg::*;

    localparam int LAT  = 2;
    localparam int R0   = 1;
    localparam int R1   = 2;
    localparam int NCYC = 2000;
    localparam int TAIL = 40;
    localparam int INF  = 32'h7fff_ffff;

    typedef struct {
        int cyc;
        int idx;
        int last;
    } tap_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    bit   stop = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    view_scan_sequencer_if #(.IDX_W(idx_width(R0))) bus0 ();
    view_scan_sequencer_if #(.IDX_W(idx_width(R1))) bus1 ();

    view_scan_sequencer #(.RADIUS(R0), .PIPE_LAT(LAT)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    view_scan_sequencer #(.RADIUS(R1), .PIPE_LAT(LAT)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Reference model state (per DUT) and scoreboard queues.
    bit   m_known [2];
    bit   m_scan [2];
    int   m_p [2];
    int   m_ready_at [2];
    int   m_addr [2];
    int   m_mode [2];
    tap_t tq0[$];
    tap_t tq1[$];
    int   dq0[$];
    int   dq1[$];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic int radius_of(input int k);
        return (k == 0) ? R0 : R1;
    endfunction

    function automatic void chk(input string what, input int k, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s dut%0d cycle %0d: got %0d, expected %0d", what, k, cyc, act, exp);
        end
    endfunction

    // Advance the model over the clock edge that ends cycle c.
    function automatic void model_step(input int k, input int c, input bit rs, input bit sv,
                                       input bit hd, input int ad, input int md);
        int w;
        int n;
        tap_t t;
        w = 2 * radius_of(k) + 1;
        n = w * w;
        if (rs) begin
            m_known[k]    = 1'b1;
            m_scan[k]     = 1'b0;
            m_addr[k]     = 0;
            m_mode[k]     = 0;
            m_ready_at[k] = c + 1;
            if (k == 0) begin tq0.delete(); dq0.delete(); end
            else begin tq1.delete(); dq1.delete(); end
        end else if (m_known[k]) begin
            if (m_scan[k]) begin
                if (!hd) begin
                    t.cyc  = c + LAT;
                    t.idx  = m_p[k];
                    t.last = (m_p[k] == n - 1) ? 1 : 0;
                    if (k == 0) tq0.push_back(t); else tq1.push_back(t);
                    if (m_p[k] == n - 1) begin
                        m_scan[k]     = 1'b0;
                        m_ready_at[k] = c + LAT + 2;
                        if (k == 0) dq0.push_back(c + LAT + 1); else dq1.push_back(c + LAT + 1);
                    end else begin
                        m_p[k]++;
                    end
                end
            end else if (sv && c >= m_ready_at[k]) begin
                m_addr[k]     = ad;
                m_mode[k]     = md;
                m_scan[k]     = 1'b1;
                m_p[k]        = 0;
                m_ready_at[k] = INF;
            end
        end
    endfunction

    initial begin : driver
        bit sv;
        bit hd;
        bit rs;
        int ad;
        int md;
        rst = 1'b1;
        bus0.start_valid = 1'b0; bus0.start_addr = '0; bus0.start_mode = '0; bus0.hold = 1'b0;
        bus1.start_valid = 1'b0; bus1.start_addr = '0; bus1.start_mode = '0; bus1.hold = 1'b0;
        for (int i = 0; i < NCYC + TAIL; i++) begin
            @(negedge clk);
            #1;
            if (i < 2) rs = 1'b1;
            else if (i >= NCYC) rs = 1'b0;
            else rs = ($urandom_range(0, 199) == 0);
            if (i >= NCYC) begin
                sv = 1'b0;
                hd = 1'b0;
            end else if (i < NCYC / 2) begin
                sv = ($urandom_range(0, 9) < 6);
                hd = ($urandom_range(0, 3) == 0);
            end else begin
                sv = 1'b1;
                hd = 1'b0;
            end
            ad = int'($urandom_range(0, 63));
            md = ($urandom_range(0, 1) == 1) ? MODE_WORD : MODE_BLOCK;
            rst = rs;
            bus0.start_valid = sv; bus0.start_addr = ad[5:0]; bus0.start_mode = md[1:0];
            bus0.hold = hd;
            bus1.start_valid = sv; bus1.start_addr = ad[5:0]; bus1.start_mode = md[1:0];
            bus1.hold = hd;
            for (int k = 0; k < 2; k++) model_step(k, cyc, rs, sv, hd, ad, md);
        end
        stop = 1'b1;
    end

    initial begin : monitor
        int   c;
        int   r;
        int   w;
        int   exp_rdy;
        int   ex;
        int   ey;
        int   due;
        tap_t e;
        int   s_rdy, s_busy, s_rw, s_addr, s_mode, s_offx, s_offy;
        int   s_tv, s_ti, s_tl, s_done;
        while (!stop) begin
            @(negedge clk);
            c = cyc;
            for (int k = 0; k < 2; k++) begin
                if (k == 0) begin
                    s_rdy  = int'(bus0.start_ready); s_busy = int'(bus0.busy);
                    s_rw   = int'(bus0.rw);          s_addr = int'(bus0.mem_addr);
                    s_mode = int'(bus0.view_mode);
                    s_offx = int'($signed(bus0.view_off_x));
                    s_offy = int'($signed(bus0.view_off_y));
                    s_tv   = int'(bus0.tap_valid);   s_ti   = int'(bus0.tap_idx);
                    s_tl   = int'(bus0.tap_last);    s_done = int'(bus0.done);
                end else begin
                    s_rdy  = int'(bus1.start_ready); s_busy = int'(bus1.busy);
                    s_rw   = int'(bus1.rw);          s_addr = int'(bus1.mem_addr);
                    s_mode = int'(bus1.view_mode);
                    s_offx = int'($signed(bus1.view_off_x));
                    s_offy = int'($signed(bus1.view_off_y));
                    s_tv   = int'(bus1.tap_valid);   s_ti   = int'(bus1.tap_idx);
                    s_tl   = int'(bus1.tap_last);    s_done = int'(bus1.done);
                end
                if (m_known[k]) begin
                    r = radius_of(k);
                    w = 2 * r + 1;
                    exp_rdy = (!m_scan[k] && c >= m_ready_at[k]) ? 1 : 0;
                    chk("start_ready", k, s_rdy, exp_rdy);
                    chk("busy", k, s_busy, 1 - exp_rdy);
                    chk("rw", k, s_rw, 1);
                    chk("mem_addr", k, s_addr, m_addr[k]);
                    chk("view_mode", k, s_mode, m_mode[k]);
                    if (m_scan[k]) begin
                        ex = (m_p[k] % w) - r;
                        ey = (m_p[k] / w) - r;
                        chk("view_off_x", k, s_offx, ex);
                        chk("view_off_y", k, s_offy, ey);
                    end else if (exp_rdy == 1) begin
                        chk("idle_off_x", k, s_offx, 0);
                        chk("idle_off_y", k, s_offy, 0);
                    end
                    due = 0;
                    if (k == 0) begin
                        if (tq0.size() > 0 && tq0[0].cyc == c) begin e = tq0.pop_front(); due = 1; end
                    end else begin
                        if (tq1.size() > 0 && tq1[0].cyc == c) begin e = tq1.pop_front(); due = 1; end
                    end
                    if (due == 1) begin
                        chk("tap_valid", k, s_tv, 1);
                        chk("tap_idx", k, s_ti, e.idx);
                        chk("tap_last", k, s_tl, e.last);
                    end else begin
                        chk("tap_valid_bubble", k, s_tv, 0);
                        chk("tap_idx_bubble", k, s_ti, 0);
                        chk("tap_last_bubble", k, s_tl, 0);
                    end
                    due = 0;
                    if (k == 0) begin
                        if (dq0.size() > 0 && dq0[0] == c) begin void'(dq0.pop_front()); due = 1; end
                    end else begin
                        if (dq1.size() > 0 && dq1[0] == c) begin void'(dq1.pop_front()); due = 1; end
                    end
                    chk("done", k, s_done, due);
                end
            end
        end
        chk("pending_taps", 0, tq0.size(), 0);
        chk("pending_taps", 1, tq1.size(), 0);
        chk("pending_done", 0, dq0.size(), 0);
        chk("pending_done", 1, dq1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
